// File: rtl/lcd_window_sequencer.sv
// ---------------------------------------------------------------------------
// lcd_window_sequencer
//
// Bus-side sequencer for an 8080-style 16-bit parallel LCD interface.
// An init pulse plays a fixed power-up command list (with long settle waits
// after soft reset and sleep-out). A color pulse programs the column/page
// window, issues memory write and streams one fill colour over every pixel.
//
// Ports:
//   HCLK, HRESETn   clock, asynchronous active-low reset
//   lcd_rstn_in     0 = synchronous abort back to IDLE (no done, no err)
//   ini_en          1-cycle start pulse for the init list
//   color_en        1-cycle start pulse for a window fill
//   set_sc/ec/sp/ep window coordinates (low COORD_W bits used)
//   color           RGB565 fill value, sampled once at start
//   busy            sequence in progress
//   done            1-cycle pulse at sequence end (also with err)
//   err             1-cycle pulse: fill rejected because end < start
//   lcd_cs_n/rs/wr_n/rd_n/data  panel bus
//
// Every bus write is wr_n low for WR_LOW cycles then high for WR_HIGH cycles,
// with rs/data launched together with the falling edge and held for the full
// period. The next write may launch on the cycle right after the last high
// cycle, so consecutive writes have no gap. RST_WAIT and SLP_WAIT must be >= 1.
// ---------------------------------------------------------------------------
module lcd_window_sequencer #(
    parameter int COORD_W  = 10,
    parameter int WR_LOW   = 2,
    parameter int WR_HIGH  = 2,
    parameter int RST_WAIT = 600000,
    parameter int SLP_WAIT = 600000
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        lcd_rstn_in,
    input  logic        ini_en,
    input  logic        color_en,
    input  logic [31:0] set_sc,
    input  logic [31:0] set_ec,
    input  logic [31:0] set_sp,
    input  logic [31:0] set_ep,
    input  logic [15:0] color,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        lcd_cs_n,
    output logic        lcd_rs,
    output logic        lcd_wr_n,
    output logic        lcd_rd_n,
    output logic [15:0] lcd_data
);

    localparam int PH_W     = $clog2(WR_LOW + WR_HIGH + 1);
    localparam int MAX_WAIT = (RST_WAIT > SLP_WAIT) ? RST_WAIT : SLP_WAIT;
    localparam int WAIT_W   = $clog2(MAX_WAIT + 1);
    localparam int CNT_W    = 2 * COORD_W + 1;

    localparam logic [15:0] CMD_CASET = 16'h002A;
    localparam logic [15:0] CMD_PASET = 16'h002B;
    localparam logic [15:0] CMD_RAMWR = 16'h002C;

    typedef enum logic [2:0] {
        IDLE,
        INIT_CMD,
        INIT_WAIT,
        WIN_CMD,
        PIXEL,
        FINISH
    } state_t;

    state_t               state;
    logic [PH_W-1:0]      ph;
    logic [3:0]           idx;
    logic [WAIT_W-1:0]    wcnt;
    logic [CNT_W-1:0]     npix_q;
    logic [CNT_W-1:0]     pix_left;
    logic [COORD_W-1:0]   sc_q, ec_q, sp_q, ep_q;
    logic [15:0]          color_q;

    // The panel is write-only from this block.
    assign lcd_rd_n = 1'b1;

    // Coordinate bits above COORD_W are ignored by design.
    logic unused_bits;
    assign unused_bits = ^{set_sc[31:COORD_W], set_ec[31:COORD_W],
                           set_sp[31:COORD_W], set_ep[31:COORD_W]};

    logic [COORD_W-1:0] sc_in, ec_in, sp_in, ep_in;
    assign sc_in = set_sc[COORD_W-1:0];
    assign ec_in = set_ec[COORD_W-1:0];
    assign sp_in = set_sp[COORD_W-1:0];
    assign ep_in = set_ep[COORD_W-1:0];

    logic bad_win;
    assign bad_win = (ec_in < sc_in) || (ep_in < sp_in);

    // Window size; one extra bit so a full-range span (2^COORD_W) fits, and
    // the product of two such spans fits exactly in CNT_W bits.
    logic [COORD_W:0]   w_in, h_in;
    logic [CNT_W-1:0]   npix_in;
    assign w_in    = {1'b0, ec_in} - {1'b0, sc_in} + (COORD_W+1)'(1);
    assign h_in    = {1'b0, ep_in} - {1'b0, sp_in} + (COORD_W+1)'(1);
    assign npix_in = CNT_W'(w_in) * CNT_W'(h_in);

    logic [15:0] sc16, ec16, sp16, ep16;
    assign sc16 = 16'(sc_q);
    assign ec16 = 16'(ec_q);
    assign sp16 = 16'(sp_q);
    assign ep16 = 16'(ep_q);

    logic wr_low_end, wr_last, in_write;
    assign wr_low_end = (ph == PH_W'(WR_LOW - 1));
    assign wr_last    = (ph == PH_W'(WR_LOW + WR_HIGH - 1));
    assign in_write   = (state == INIT_CMD) || (state == WIN_CMD) || (state == PIXEL);

    // {rs, data} of each init-list write.
    function automatic logic [16:0] init_word(input logic [2:0] i);
        case (i)
            3'd0:    init_word = {1'b0, 16'h0001};
            3'd1:    init_word = {1'b0, 16'h0011};
            3'd2:    init_word = {1'b0, 16'h003A};
            3'd3:    init_word = {1'b1, 16'h0055};
            default: init_word = {1'b0, 16'h0029};
        endcase
    endfunction

    // {rs, data} of each window-setup write; coordinate bytes go out
    // high byte first, zero-extended to the 16-bit bus.
    function automatic logic [16:0] win_word(input logic [3:0]  i,
                                             input logic [15:0] sc,
                                             input logic [15:0] ec,
                                             input logic [15:0] sp,
                                             input logic [15:0] ep);
        case (i)
            4'd0:    win_word = {1'b0, CMD_CASET};
            4'd1:    win_word = {1'b1, 8'h00, sc[15:8]};
            4'd2:    win_word = {1'b1, 8'h00, sc[7:0]};
            4'd3:    win_word = {1'b1, 8'h00, ec[15:8]};
            4'd4:    win_word = {1'b1, 8'h00, ec[7:0]};
            4'd5:    win_word = {1'b0, CMD_PASET};
            4'd6:    win_word = {1'b1, 8'h00, sp[15:8]};
            4'd7:    win_word = {1'b1, 8'h00, sp[7:0]};
            4'd8:    win_word = {1'b1, 8'h00, ep[15:8]};
            4'd9:    win_word = {1'b1, 8'h00, ep[7:0]};
            default: win_word = {1'b0, CMD_RAMWR};
        endcase
    endfunction

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            lcd_cs_n <= 1'b1;
            lcd_wr_n <= 1'b1;
            lcd_rs   <= 1'b0;
            lcd_data <= '0;
            ph       <= '0;
            idx      <= '0;
            wcnt     <= '0;
            npix_q   <= '0;
            pix_left <= '0;
            sc_q     <= '0;
            ec_q     <= '0;
            sp_q     <= '0;
            ep_q     <= '0;
            color_q  <= '0;
        end else if (!lcd_rstn_in) begin
            // Abort: drop the bus and go quiet; rs/data simply hold.
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            lcd_cs_n <= 1'b1;
            lcd_wr_n <= 1'b1;
            ph       <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;

            // Write phase counter; the state case below only acts on wr_last.
            if (in_write && !wr_last) begin
                ph <= ph + PH_W'(1);
                if (wr_low_end) lcd_wr_n <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (ini_en) begin
                        state             <= INIT_CMD;
                        busy              <= 1'b1;
                        lcd_cs_n          <= 1'b0;
                        idx               <= '0;
                        {lcd_rs, lcd_data} <= init_word(3'd0);
                        lcd_wr_n          <= 1'b0;
                        ph                <= '0;
                    end else if (color_en) begin
                        if (bad_win) begin
                            err  <= 1'b1;
                            done <= 1'b1;
                        end else begin
                            state             <= WIN_CMD;
                            busy              <= 1'b1;
                            lcd_cs_n          <= 1'b0;
                            idx               <= '0;
                            sc_q              <= sc_in;
                            ec_q              <= ec_in;
                            sp_q              <= sp_in;
                            ep_q              <= ep_in;
                            color_q           <= color;
                            npix_q            <= npix_in;
                            {lcd_rs, lcd_data} <= {1'b0, CMD_CASET};
                            lcd_wr_n          <= 1'b0;
                            ph                <= '0;
                        end
                    end
                end

                INIT_CMD: begin
                    if (wr_last) begin
                        if (idx == 4'd4) begin
                            state    <= FINISH;
                            lcd_cs_n <= 1'b1;
                            done     <= 1'b1;
                        end else if (idx == 4'd0 || idx == 4'd1) begin
                            // Soft reset and sleep-out need a settle time
                            // counted from the end of their high phase.
                            state <= INIT_WAIT;
                            idx   <= idx + 4'd1;
                            wcnt  <= (idx == 4'd0) ? WAIT_W'(RST_WAIT - 1)
                                                   : WAIT_W'(SLP_WAIT - 1);
                        end else begin
                            idx               <= idx + 4'd1;
                            {lcd_rs, lcd_data} <= init_word(idx[2:0] + 3'd1);
                            lcd_wr_n          <= 1'b0;
                            ph                <= '0;
                        end
                    end
                end

                INIT_WAIT: begin
                    if (wcnt == '0) begin
                        state             <= INIT_CMD;
                        {lcd_rs, lcd_data} <= init_word(idx[2:0]);
                        lcd_wr_n          <= 1'b0;
                        ph                <= '0;
                    end else begin
                        wcnt <= wcnt - WAIT_W'(1);
                    end
                end

                WIN_CMD: begin
                    if (wr_last) begin
                        if (idx == 4'd10) begin
                            state             <= PIXEL;
                            pix_left          <= npix_q - CNT_W'(1);
                            {lcd_rs, lcd_data} <= {1'b1, color_q};
                        end else begin
                            idx               <= idx + 4'd1;
                            {lcd_rs, lcd_data} <= win_word(idx + 4'd1, sc16, ec16, sp16, ep16);
                        end
                        lcd_wr_n <= 1'b0;
                        ph       <= '0;
                    end
                end

                PIXEL: begin
                    if (wr_last) begin
                        if (pix_left == '0) begin
                            state    <= FINISH;
                            lcd_cs_n <= 1'b1;
                            done     <= 1'b1;
                        end else begin
                            pix_left          <= pix_left - CNT_W'(1);
                            {lcd_rs, lcd_data} <= {1'b1, color_q};
                            lcd_wr_n          <= 1'b0;
                            ph                <= '0;
                        end
                    end
                end

                FINISH: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_window_sequencer.sv
// ---------------------------------------------------------------------------
// tb_lcd_window_sequencer
//
// Bench for lcd_window_sequencer with short init waits. A reference model
// turns each requested operation into the list of bus writes ({rs, data})
// and inter-write high times it must produce; a bus monitor reconstructs
// writes from lcd_wr_n edges and compares them in order.
// ---------------------------------------------------------------------------
module tb_lcd_window_sequencer;

    localparam int COORD_W  = 10;
    localparam int WR_LOW   = 2;
    localparam int WR_HIGH  = 2;
    localparam int RST_WAIT = 8;
    localparam int SLP_WAIT = 8;

    // ---------------- clock / reset / DUT ----------------
    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        lcd_rstn_in = 1'b1;
    logic        ini_en = 1'b0;
    logic        color_en = 1'b0;
    logic [31:0] set_sc = '0, set_ec = '0, set_sp = '0, set_ep = '0;
    logic [15:0] color = '0;
    logic        busy, done, err, lcd_cs_n, lcd_rs, lcd_wr_n, lcd_rd_n;
    logic [15:0] lcd_data;

    always #5 HCLK = ~HCLK;

    lcd_window_sequencer #(
        .COORD_W (COORD_W),
        .WR_LOW  (WR_LOW),
        .WR_HIGH (WR_HIGH),
        .RST_WAIT(RST_WAIT),
        .SLP_WAIT(SLP_WAIT)
    ) dut (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .lcd_rstn_in(lcd_rstn_in),
        .ini_en     (ini_en),
        .color_en   (color_en),
        .set_sc     (set_sc),
        .set_ec     (set_ec),
        .set_sp     (set_sp),
        .set_ep     (set_ep),
        .color      (color),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .lcd_cs_n   (lcd_cs_n),
        .lcd_rs     (lcd_rs),
        .lcd_wr_n   (lcd_wr_n),
        .lcd_rd_n   (lcd_rd_n),
        .lcd_data   (lcd_data)
    );

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_errors = 0;
    logic [16:0] exp_q[$];
    int          exp_gap_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- bus monitor ----------------
    int          wr_total = 0;
    int          extra_cnt = 0;
    int          done_cnt = 0;
    int          err_cnt = 0;
    int          lo_cnt = 0;
    int          hi_cnt = 0;
    int          g;
    logic        prev_wr = 1'b1;
    logic        prev_cs = 1'b1;
    logic [16:0] cur_word = '0;

    always @(negedge HCLK) begin
        if (!HRESETn) begin
            prev_wr = 1'b1;
            prev_cs = 1'b1;
        end else begin
            if (done) done_cnt++;
            if (err)  err_cnt++;
            if (!lcd_wr_n) begin
                if (prev_wr) begin
                    cur_word = {lcd_rs, lcd_data};
                    g = -1;
                    if (exp_gap_q.size() > 0) g = exp_gap_q.pop_front();
                    check("cs_n_during_write", {31'd0, lcd_cs_n}, 32'd0);
                    if (!prev_cs && g >= 0) check("write_gap", hi_cnt, g);
                    lo_cnt = 1;
                end else begin
                    lo_cnt++;
                end
            end else if (!prev_wr) begin
                check("wr_low_len", lo_cnt, WR_LOW);
                check("rs_data_hold", {15'd0, lcd_rs, lcd_data}, {15'd0, cur_word});
                if (exp_q.size() == 0) extra_cnt++;
                else check("write_word", {15'd0, cur_word}, {15'd0, exp_q.pop_front()});
                wr_total++;
                hi_cnt = 1;
            end else begin
                hi_cnt++;
            end
            prev_wr = lcd_wr_n;
            prev_cs = lcd_cs_n;
        end
    end

    // ---------------- reference model ----------------
    task automatic push_w(input logic rs, input logic [15:0] d, input int gap);
        exp_q.push_back({rs, d});
        exp_gap_q.push_back(gap);
    endtask

    task automatic model_init();
        push_w(1'b0, 16'h0001, -1);
        push_w(1'b0, 16'h0011, WR_HIGH + RST_WAIT);
        push_w(1'b0, 16'h003A, WR_HIGH + SLP_WAIT);
        push_w(1'b1, 16'h0055, WR_HIGH);
        push_w(1'b0, 16'h0029, WR_HIGH);
    endtask

    task automatic model_fill(input logic [31:0] sc_w, input logic [31:0] ec_w,
                              input logic [31:0] sp_w, input logic [31:0] ep_w,
                              input logic [15:0] col, output bit bad);
        int sc, ec, sp, ep, npix;
        sc = int'(sc_w % (1 << COORD_W));
        ec = int'(ec_w % (1 << COORD_W));
        sp = int'(sp_w % (1 << COORD_W));
        ep = int'(ep_w % (1 << COORD_W));
        bad = (ec < sc) || (ep < sp);
        if (bad) return;
        push_w(1'b0, 16'h002A, -1);
        push_w(1'b1, 16'(sc / 256), WR_HIGH);
        push_w(1'b1, 16'(sc % 256), WR_HIGH);
        push_w(1'b1, 16'(ec / 256), WR_HIGH);
        push_w(1'b1, 16'(ec % 256), WR_HIGH);
        push_w(1'b0, 16'h002B, WR_HIGH);
        push_w(1'b1, 16'(sp / 256), WR_HIGH);
        push_w(1'b1, 16'(sp % 256), WR_HIGH);
        push_w(1'b1, 16'(ep / 256), WR_HIGH);
        push_w(1'b1, 16'(ep % 256), WR_HIGH);
        push_w(1'b0, 16'h002C, WR_HIGH);
        npix = (ec - sc + 1) * (ep - sp + 1);
        for (int i = 0; i < npix; i++) push_w(1'b1, col, WR_HIGH);
    endtask

    // ---------------- driver tasks ----------------
    task automatic pulse(input logic do_ini, input logic do_col);
        @(posedge HCLK); #1;
        ini_en   = do_ini;
        color_en = do_col;
        @(posedge HCLK); #1;
        ini_en   = 1'b0;
        color_en = 1'b0;
    endtask

    task automatic check_started(input string tag);
        @(negedge HCLK);
        check({tag, "_busy_rise"}, {31'd0, busy}, 32'd1);
        check({tag, "_first_wr_low"}, {31'd0, lcd_wr_n}, 32'd0);
        check({tag, "_cs_low"}, {31'd0, lcd_cs_n}, 32'd0);
    endtask

    task automatic wait_done(input string tag, input int base_done);
        int n = 0;
        while (n < 5000 && done !== 1'b1) begin
            @(negedge HCLK);
            n++;
        end
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_finish_cs"}, {31'd0, lcd_cs_n}, 32'd1);
        @(negedge HCLK);
        check({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
        check({tag, "_done_width"}, {31'd0, done}, 32'd0);
        check({tag, "_done_count"}, done_cnt - base_done, 32'd1);
        check({tag, "_leftover"}, exp_q.size(), 32'd0);
        check({tag, "_extra_writes"}, extra_cnt, 32'd0);
    endtask

    task automatic do_init(input string tag);
        int base_d;
        model_init();
        base_d = done_cnt;
        pulse(1'b1, 1'b0);
        check_started(tag);
        wait_done(tag, base_d);
    endtask

    task automatic do_fill(input logic [31:0] sc, input logic [31:0] ec,
                           input logic [31:0] sp, input logic [31:0] ep,
                           input logic [15:0] col, input bit scramble, input string tag);
        bit   bad;
        bit   cs_seen;
        int   base_d;
        set_sc = sc; set_ec = ec; set_sp = sp; set_ep = ep; color = col;
        model_fill(sc, ec, sp, ep, col, bad);
        base_d = done_cnt;
        pulse(1'b0, 1'b1);
        if (bad) begin
            @(negedge HCLK);
            check({tag, "_err"}, {31'd0, err}, 32'd1);
            check({tag, "_err_done"}, {31'd0, done}, 32'd1);
            check({tag, "_err_busy"}, {31'd0, busy}, 32'd0);
            cs_seen = !lcd_cs_n;
            @(negedge HCLK);
            check({tag, "_err_width"}, {30'd0, err, done}, 32'd0);
            repeat (5) begin
                @(negedge HCLK);
                cs_seen = cs_seen | !lcd_cs_n;
            end
            check({tag, "_err_no_cs"}, {31'd0, cs_seen}, 32'd0);
            check({tag, "_err_no_writes"}, exp_q.size() + extra_cnt, 32'd0);
        end else begin
            check_started(tag);
            if (scramble) begin
                repeat ($urandom_range(5, 40)) @(negedge HCLK);
                set_sc = $urandom(); set_ec = $urandom();
                set_sp = $urandom(); set_ep = $urandom();
                color  = 16'($urandom());
            end
            wait_done(tag, base_d);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int   base_w, base_d, n, op, w, h, x, y;
        bit   bad;

        // reset and idle
        HRESETn = 1'b0;
        repeat (3) @(negedge HCLK);
        HRESETn = 1'b1;
        repeat (10) @(negedge HCLK);
        check("rst_cs_n", {31'd0, lcd_cs_n}, 32'd1);
        check("rst_wr_n", {31'd0, lcd_wr_n}, 32'd1);
        check("rst_rd_n", {31'd0, lcd_rd_n}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done_err", {30'd0, done, err}, 32'd0);
        check("rst_rs", {31'd0, lcd_rs}, 32'd0);
        check("rst_data", {16'd0, lcd_data}, 32'd0);

        // init list
        base_w = wr_total;
        do_init("init");
        check("init_write_count", wr_total - base_w, 32'd5);

        // directed window fill
        base_w = wr_total;
        do_fill(32'h100, 32'h101, 32'd2, 32'd3, 16'hF800, 1'b0, "fill");
        check("fill_write_count", wr_total - base_w, 32'd15);

        // init and color together, color re-pulsed while busy
        set_sc = 32'd0; set_ec = 32'd3; set_sp = 32'd0; set_ep = 32'd3; color = 16'h1234;
        model_init();
        base_w = wr_total;
        base_d = done_cnt;
        pulse(1'b1, 1'b1);
        check_started("both");
        repeat (10) @(negedge HCLK);
        pulse(1'b0, 1'b1);
        wait_done("both", base_d);
        repeat (30) @(negedge HCLK);
        check("both_write_count", wr_total - base_w, 32'd5);
        check("both_idle_after", {31'd0, busy}, 32'd0);

        // rejected windows
        do_fill(32'd5, 32'd4, 32'd0, 32'd0, 16'hAAAA, 1'b0, "bad_col");
        do_fill(32'd0, 32'd0, 32'd9, 32'd3, 16'h5555, 1'b0, "bad_page");

        // abort after the third pixel write
        set_sc = 32'd0; set_ec = 32'd9; set_sp = 32'd0; set_ep = 32'd9; color = 16'h07E0;
        model_fill(set_sc, set_ec, set_sp, set_ep, color, bad);
        base_w = wr_total;
        base_d = done_cnt;
        pulse(1'b0, 1'b1);
        n = 0;
        while (wr_total < base_w + 14 && n < 2000) begin
            @(negedge HCLK); #1;
            n++;
        end
        check("abort_reached", {31'd0, n < 2000}, 32'd1);
        lcd_rstn_in = 1'b0;
        @(negedge HCLK);
        check("abort_cs_n", {31'd0, lcd_cs_n}, 32'd1);
        check("abort_wr_n", {31'd0, lcd_wr_n}, 32'd1);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_no_done", {30'd0, done, err}, 32'd0);
        pulse(1'b1, 1'b0);
        @(negedge HCLK);
        check("abort_start_ignored", {31'd0, busy}, 32'd0);
        lcd_rstn_in = 1'b1;
        repeat (3) @(negedge HCLK);
        check("abort_write_count", wr_total - base_w, 32'd14);
        check("abort_done_count", done_cnt - base_d, 32'd0);
        exp_q.delete();
        exp_gap_q.delete();
        base_w = wr_total;
        do_fill(32'd7, 32'd7, 32'd3, 32'd3, 16'hBEEF, 1'b0, "post_abort");
        check("post_abort_count", wr_total - base_w, 32'd12);

        // coordinate boundary: top of range, upper word bits ignored
        do_fill(32'hABCD_03FE, 32'hFFFF_FFFF, 32'h0001_03FF, 32'h8000_03FF, 16'hC0DE, 1'b0, "edge");

        // HRESETn in the middle of a fill
        set_sc = 32'd1; set_ec = 32'd3; set_sp = 32'd1; set_ep = 32'd3; color = 16'h0F0F;
        model_fill(set_sc, set_ec, set_sp, set_ep, color, bad);
        pulse(1'b0, 1'b1);
        repeat (20) @(negedge HCLK);
        HRESETn = 1'b0;
        #1;
        check("hrst_cs_n", {31'd0, lcd_cs_n}, 32'd1);
        check("hrst_wr_n", {31'd0, lcd_wr_n}, 32'd1);
        check("hrst_busy", {31'd0, busy}, 32'd0);
        check("hrst_data", {15'd0, lcd_rs, lcd_data}, 32'd0);
        repeat (3) @(negedge HCLK);
        HRESETn = 1'b1;
        exp_q.delete();
        exp_gap_q.delete();

        // randomized operations, inputs scrambled mid-sequence
        for (int it = 0; it < 12; it++) begin
            op = $urandom_range(0, 4);
            if (op == 0) begin
                do_init("rnd_init");
            end else if (op == 1) begin
                x = $urandom_range(1, 1023);
                do_fill({$urandom_range(0, 255), 24'd0} | x, $urandom_range(0, x - 1),
                        $urandom_range(0, 1023), $urandom_range(0, 1023),
                        16'($urandom()), 1'b0, "rnd_bad");
            end else begin
                w = $urandom_range(1, 4);
                h = $urandom_range(1, 4);
                x = $urandom_range(0, 1024 - w);
                y = $urandom_range(0, 1024 - h);
                do_fill(($urandom() & 32'hFFFF_FC00) | x, ($urandom() & 32'hFFFF_FC00) | (x + w - 1),
                        ($urandom() & 32'hFFFF_FC00) | y, ($urandom() & 32'hFFFF_FC00) | (y + h - 1),
                        16'($urandom()), 1'b1, "rnd_fill");
            end
        end

        repeat (5) @(negedge HCLK);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Bound on total run time in case the DUT never completes a sequence.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete (checks=%0d errors=%0d)", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule
